// File: rtl/swervolf_ram_arb.sv
// Two-master to one-slave AXI4 arbiter for the shared 64-bit RAM port.
// Read and write paths are arbitrated independently, one transaction in flight per path.
module swervolf_ram_arb #(
  parameter int ID_WIDTH = 4,
  parameter int AW       = 32,
  parameter int DW       = 64
) (
  input  logic                clk,
  input  logic                rstn,
  // master 0 (core)
  input  logic [ID_WIDTH-1:0] i_m0_awid,
  input  logic [AW-1:0]       i_m0_awaddr,
  input  logic [7:0]          i_m0_awlen,
  input  logic [2:0]          i_m0_awsize,
  input  logic [1:0]          i_m0_awburst,
  input  logic                i_m0_awvalid,
  output logic                o_m0_awready,
  input  logic [DW-1:0]       i_m0_wdata,
  input  logic [DW/8-1:0]     i_m0_wstrb,
  input  logic                i_m0_wlast,
  input  logic                i_m0_wvalid,
  output logic                o_m0_wready,
  output logic [ID_WIDTH-1:0] o_m0_bid,
  output logic [1:0]          o_m0_bresp,
  output logic                o_m0_bvalid,
  input  logic                i_m0_bready,
  input  logic [ID_WIDTH-1:0] i_m0_arid,
  input  logic [AW-1:0]       i_m0_araddr,
  input  logic [7:0]          i_m0_arlen,
  input  logic [2:0]          i_m0_arsize,
  input  logic [1:0]          i_m0_arburst,
  input  logic                i_m0_arvalid,
  output logic                o_m0_arready,
  output logic [ID_WIDTH-1:0] o_m0_rid,
  output logic [DW-1:0]       o_m0_rdata,
  output logic [1:0]          o_m0_rresp,
  output logic                o_m0_rlast,
  output logic                o_m0_rvalid,
  input  logic                i_m0_rready,
  // master 1 (DMA / loader)
  input  logic [ID_WIDTH-1:0] i_m1_awid,
  input  logic [AW-1:0]       i_m1_awaddr,
  input  logic [7:0]          i_m1_awlen,
  input  logic [2:0]          i_m1_awsize,
  input  logic [1:0]          i_m1_awburst,
  input  logic                i_m1_awvalid,
  output logic                o_m1_awready,
  input  logic [DW-1:0]       i_m1_wdata,
  input  logic [DW/8-1:0]     i_m1_wstrb,
  input  logic                i_m1_wlast,
  input  logic                i_m1_wvalid,
  output logic                o_m1_wready,
  output logic [ID_WIDTH-1:0] o_m1_bid,
  output logic [1:0]          o_m1_bresp,
  output logic                o_m1_bvalid,
  input  logic                i_m1_bready,
  input  logic [ID_WIDTH-1:0] i_m1_arid,
  input  logic [AW-1:0]       i_m1_araddr,
  input  logic [7:0]          i_m1_arlen,
  input  logic [2:0]          i_m1_arsize,
  input  logic [1:0]          i_m1_arburst,
  input  logic                i_m1_arvalid,
  output logic                o_m1_arready,
  output logic [ID_WIDTH-1:0] o_m1_rid,
  output logic [DW-1:0]       o_m1_rdata,
  output logic [1:0]          o_m1_rresp,
  output logic                o_m1_rlast,
  output logic                o_m1_rvalid,
  input  logic                i_m1_rready,
  // slave (memory)
  output logic [ID_WIDTH-1:0] o_s_awid,
  output logic [AW-1:0]       o_s_awaddr,
  output logic [7:0]          o_s_awlen,
  output logic [2:0]          o_s_awsize,
  output logic [1:0]          o_s_awburst,
  output logic                o_s_awvalid,
  input  logic                i_s_awready,
  output logic [DW-1:0]       o_s_wdata,
  output logic [DW/8-1:0]     o_s_wstrb,
  output logic                o_s_wlast,
  output logic                o_s_wvalid,
  input  logic                i_s_wready,
  input  logic [ID_WIDTH-1:0] i_s_bid,
  input  logic [1:0]          i_s_bresp,
  input  logic                i_s_bvalid,
  output logic                o_s_bready,
  output logic [ID_WIDTH-1:0] o_s_arid,
  output logic [AW-1:0]       o_s_araddr,
  output logic [7:0]          o_s_arlen,
  output logic [2:0]          o_s_arsize,
  output logic [1:0]          o_s_arburst,
  output logic                o_s_arvalid,
  input  logic                i_s_arready,
  input  logic [ID_WIDTH-1:0] i_s_rid,
  input  logic [DW-1:0]       i_s_rdata,
  input  logic [1:0]          i_s_rresp,
  input  logic                i_s_rlast,
  input  logic                i_s_rvalid,
  output logic                o_s_rready,
  // FSM state observation
  output logic [1:0]          o_dbg_wstate,
  output logic [1:0]          o_dbg_rstate
);

  // Handshakes: a beat transfers on the rising edge where valid and ready are both 1;
  // valid never depends on ready, and ready/valid are only passed to the granted master.

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3} wstate_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rstate_t;

  wstate_t wstate, wstate_nxt;
  rstate_t rstate, rstate_nxt;
  logic    wgnt, wgnt_nxt, wlast_gnt, wlast_gnt_nxt;
  logic    rgnt, rgnt_nxt, rlast_gnt, rlast_gnt_nxt;

  // Contention goes to the master that was not served last.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
    if (req0 && req1) return ~last;
    return req1;
  endfunction

  logic [ID_WIDTH-1:0] sel_awid, sel_arid;
  logic [AW-1:0]       sel_awaddr, sel_araddr;
  logic [7:0]          sel_awlen, sel_arlen;
  logic [2:0]          sel_awsize, sel_arsize;
  logic [1:0]          sel_awburst, sel_arburst;
  logic                sel_awvalid, sel_arvalid;
  logic [DW-1:0]       sel_wdata;
  logic [DW/8-1:0]     sel_wstrb;
  logic                sel_wlast, sel_wvalid, sel_bready, sel_rready;

  assign sel_awid    = wgnt ? i_m1_awid    : i_m0_awid;
  assign sel_awaddr  = wgnt ? i_m1_awaddr  : i_m0_awaddr;
  assign sel_awlen   = wgnt ? i_m1_awlen   : i_m0_awlen;
  assign sel_awsize  = wgnt ? i_m1_awsize  : i_m0_awsize;
  assign sel_awburst = wgnt ? i_m1_awburst : i_m0_awburst;
  assign sel_awvalid = wgnt ? i_m1_awvalid : i_m0_awvalid;
  assign sel_wdata   = wgnt ? i_m1_wdata   : i_m0_wdata;
  assign sel_wstrb   = wgnt ? i_m1_wstrb   : i_m0_wstrb;
  assign sel_wlast   = wgnt ? i_m1_wlast   : i_m0_wlast;
  assign sel_wvalid  = wgnt ? i_m1_wvalid  : i_m0_wvalid;
  assign sel_bready  = wgnt ? i_m1_bready  : i_m0_bready;
  assign sel_arid    = rgnt ? i_m1_arid    : i_m0_arid;
  assign sel_araddr  = rgnt ? i_m1_araddr  : i_m0_araddr;
  assign sel_arlen   = rgnt ? i_m1_arlen   : i_m0_arlen;
  assign sel_arsize  = rgnt ? i_m1_arsize  : i_m0_arsize;
  assign sel_arburst = rgnt ? i_m1_arburst : i_m0_arburst;
  assign sel_arvalid = rgnt ? i_m1_arvalid : i_m0_arvalid;
  assign sel_rready  = rgnt ? i_m1_rready  : i_m0_rready;

  assign o_dbg_wstate = wstate;
  assign o_dbg_rstate = rstate;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wstate    <= W_IDLE;
      wgnt      <= 1'b0;
      wlast_gnt <= 1'b1;
      rstate    <= R_IDLE;
      rgnt      <= 1'b0;
      rlast_gnt <= 1'b1;
    end else begin
      wstate    <= wstate_nxt;
      wgnt      <= wgnt_nxt;
      wlast_gnt <= wlast_gnt_nxt;
      rstate    <= rstate_nxt;
      rgnt      <= rgnt_nxt;
      rlast_gnt <= rlast_gnt_nxt;
    end
  end

  always_comb begin
    wstate_nxt    = wstate;
    wgnt_nxt      = wgnt;
    wlast_gnt_nxt = wlast_gnt;
    case (wstate)
      W_IDLE: if (i_m0_awvalid || i_m1_awvalid) begin
        wgnt_nxt   = rr_pick(i_m0_awvalid, i_m1_awvalid, wlast_gnt);
        wstate_nxt = W_ADDR;
      end
      W_ADDR: if (sel_awvalid && i_s_awready) wstate_nxt = W_DATA;
      W_DATA: if (sel_wvalid && i_s_wready && sel_wlast) wstate_nxt = W_RESP;
      W_RESP: if (i_s_bvalid && sel_bready) begin
        wstate_nxt    = W_IDLE;
        wlast_gnt_nxt = wgnt;
      end
      default: wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    o_s_awid = '0; o_s_awaddr = '0; o_s_awlen = '0; o_s_awsize = '0; o_s_awburst = '0;
    o_s_awvalid = 1'b0;
    o_s_wdata = '0; o_s_wstrb = '0; o_s_wlast = 1'b0; o_s_wvalid = 1'b0;
    o_s_bready = 1'b0;
    o_m0_awready = 1'b0; o_m1_awready = 1'b0;
    o_m0_wready  = 1'b0; o_m1_wready  = 1'b0;
    o_m0_bid = '0; o_m0_bresp = '0; o_m0_bvalid = 1'b0;
    o_m1_bid = '0; o_m1_bresp = '0; o_m1_bvalid = 1'b0;
    case (wstate)
      W_ADDR: begin
        o_s_awid     = sel_awid;
        o_s_awaddr   = sel_awaddr;
        o_s_awlen    = sel_awlen;
        o_s_awsize   = sel_awsize;
        o_s_awburst  = sel_awburst;
        o_s_awvalid  = sel_awvalid;
        o_m0_awready = ~wgnt & i_s_awready;
        o_m1_awready =  wgnt & i_s_awready;
      end
      W_DATA: begin
        o_s_wdata   = sel_wdata;
        o_s_wstrb   = sel_wstrb;
        o_s_wlast   = sel_wlast;
        o_s_wvalid  = sel_wvalid;
        o_m0_wready = ~wgnt & i_s_wready;
        o_m1_wready =  wgnt & i_s_wready;
      end
      W_RESP: begin
        o_s_bready = sel_bready;
        if (wgnt) begin
          o_m1_bid = i_s_bid; o_m1_bresp = i_s_bresp; o_m1_bvalid = i_s_bvalid;
        end else begin
          o_m0_bid = i_s_bid; o_m0_bresp = i_s_bresp; o_m0_bvalid = i_s_bvalid;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    rstate_nxt    = rstate;
    rgnt_nxt      = rgnt;
    rlast_gnt_nxt = rlast_gnt;
    case (rstate)
      R_IDLE: if (i_m0_arvalid || i_m1_arvalid) begin
        rgnt_nxt   = rr_pick(i_m0_arvalid, i_m1_arvalid, rlast_gnt);
        rstate_nxt = R_ADDR;
      end
      R_ADDR: if (sel_arvalid && i_s_arready) rstate_nxt = R_DATA;
      R_DATA: if (i_s_rvalid && sel_rready && i_s_rlast) begin
        rstate_nxt    = R_IDLE;
        rlast_gnt_nxt = rgnt;
      end
      default: rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    o_s_arid = '0; o_s_araddr = '0; o_s_arlen = '0; o_s_arsize = '0; o_s_arburst = '0;
    o_s_arvalid = 1'b0;
    o_s_rready = 1'b0;
    o_m0_arready = 1'b0; o_m1_arready = 1'b0;
    o_m0_rid = '0; o_m0_rdata = '0; o_m0_rresp = '0; o_m0_rlast = 1'b0; o_m0_rvalid = 1'b0;
    o_m1_rid = '0; o_m1_rdata = '0; o_m1_rresp = '0; o_m1_rlast = 1'b0; o_m1_rvalid = 1'b0;
    case (rstate)
      R_ADDR: begin
        o_s_arid     = sel_arid;
        o_s_araddr   = sel_araddr;
        o_s_arlen    = sel_arlen;
        o_s_arsize   = sel_arsize;
        o_s_arburst  = sel_arburst;
        o_s_arvalid  = sel_arvalid;
        o_m0_arready = ~rgnt & i_s_arready;
        o_m1_arready =  rgnt & i_s_arready;
      end
      R_DATA: begin
        o_s_rready = sel_rready;
        if (rgnt) begin
          o_m1_rid = i_s_rid; o_m1_rdata = i_s_rdata; o_m1_rresp = i_s_rresp;
          o_m1_rlast = i_s_rlast; o_m1_rvalid = i_s_rvalid;
        end else begin
          o_m0_rid = i_s_rid; o_m0_rdata = i_s_rdata; o_m0_rresp = i_s_rresp;
          o_m0_rlast = i_s_rlast; o_m0_rvalid = i_s_rvalid;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_swervolf_ram_arb.sv
// Directed bench for swervolf_ram_arb: write/read bursts, round-robin order,
// concurrent paths, slave back-pressure, error responses and mid-burst reset.
module tb_swervolf_ram_arb;
  localparam int IW = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [IW-1:0] m_awid[2];
  logic [AW-1:0] m_awaddr[2];
  logic [7:0]    m_awlen[2];
  logic [2:0]    m_awsize[2];
  logic [1:0]    m_awburst[2];
  logic [1:0]    m_awvalid, m_awready;
  logic [DW-1:0] m_wdata[2];
  logic [SW-1:0] m_wstrb[2];
  logic [1:0]    m_wlast, m_wvalid, m_wready;
  logic [IW-1:0] m_bid[2];
  logic [1:0]    m_bresp[2];
  logic [1:0]    m_bvalid, m_bready;
  logic [IW-1:0] m_arid[2];
  logic [AW-1:0] m_araddr[2];
  logic [7:0]    m_arlen[2];
  logic [2:0]    m_arsize[2];
  logic [1:0]    m_arburst[2];
  logic [1:0]    m_arvalid, m_arready;
  logic [IW-1:0] m_rid[2];
  logic [DW-1:0] m_rdata[2];
  logic [1:0]    m_rresp[2];
  logic [1:0]    m_rlast, m_rvalid, m_rready;

  logic [IW-1:0] s_awid, s_arid, s_bid, s_rid;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [7:0]    s_awlen, s_arlen;
  logic [2:0]    s_awsize, s_arsize;
  logic [1:0]    s_awburst, s_arburst, s_bresp, s_rresp;
  logic          s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
  logic          s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [SW-1:0] s_wstrb;
  logic [1:0]    dbg_wstate, dbg_rstate;

  swervolf_ram_arb #(.ID_WIDTH(IW), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rstn(rstn),
    .i_m0_awid(m_awid[0]), .i_m0_awaddr(m_awaddr[0]), .i_m0_awlen(m_awlen[0]),
    .i_m0_awsize(m_awsize[0]), .i_m0_awburst(m_awburst[0]), .i_m0_awvalid(m_awvalid[0]),
    .o_m0_awready(m_awready[0]),
    .i_m0_wdata(m_wdata[0]), .i_m0_wstrb(m_wstrb[0]), .i_m0_wlast(m_wlast[0]),
    .i_m0_wvalid(m_wvalid[0]), .o_m0_wready(m_wready[0]),
    .o_m0_bid(m_bid[0]), .o_m0_bresp(m_bresp[0]), .o_m0_bvalid(m_bvalid[0]), .i_m0_bready(m_bready[0]),
    .i_m0_arid(m_arid[0]), .i_m0_araddr(m_araddr[0]), .i_m0_arlen(m_arlen[0]),
    .i_m0_arsize(m_arsize[0]), .i_m0_arburst(m_arburst[0]), .i_m0_arvalid(m_arvalid[0]),
    .o_m0_arready(m_arready[0]),
    .o_m0_rid(m_rid[0]), .o_m0_rdata(m_rdata[0]), .o_m0_rresp(m_rresp[0]), .o_m0_rlast(m_rlast[0]),
    .o_m0_rvalid(m_rvalid[0]), .i_m0_rready(m_rready[0]),
    .i_m1_awid(m_awid[1]), .i_m1_awaddr(m_awaddr[1]), .i_m1_awlen(m_awlen[1]),
    .i_m1_awsize(m_awsize[1]), .i_m1_awburst(m_awburst[1]), .i_m1_awvalid(m_awvalid[1]),
    .o_m1_awready(m_awready[1]),
    .i_m1_wdata(m_wdata[1]), .i_m1_wstrb(m_wstrb[1]), .i_m1_wlast(m_wlast[1]),
    .i_m1_wvalid(m_wvalid[1]), .o_m1_wready(m_wready[1]),
    .o_m1_bid(m_bid[1]), .o_m1_bresp(m_bresp[1]), .o_m1_bvalid(m_bvalid[1]), .i_m1_bready(m_bready[1]),
    .i_m1_arid(m_arid[1]), .i_m1_araddr(m_araddr[1]), .i_m1_arlen(m_arlen[1]),
    .i_m1_arsize(m_arsize[1]), .i_m1_arburst(m_arburst[1]), .i_m1_arvalid(m_arvalid[1]),
    .o_m1_arready(m_arready[1]),
    .o_m1_rid(m_rid[1]), .o_m1_rdata(m_rdata[1]), .o_m1_rresp(m_rresp[1]), .o_m1_rlast(m_rlast[1]),
    .o_m1_rvalid(m_rvalid[1]), .i_m1_rready(m_rready[1]),
    .o_s_awid(s_awid), .o_s_awaddr(s_awaddr), .o_s_awlen(s_awlen), .o_s_awsize(s_awsize),
    .o_s_awburst(s_awburst), .o_s_awvalid(s_awvalid), .i_s_awready(s_awready),
    .o_s_wdata(s_wdata), .o_s_wstrb(s_wstrb), .o_s_wlast(s_wlast), .o_s_wvalid(s_wvalid),
    .i_s_wready(s_wready),
    .i_s_bid(s_bid), .i_s_bresp(s_bresp), .i_s_bvalid(s_bvalid), .o_s_bready(s_bready),
    .o_s_arid(s_arid), .o_s_araddr(s_araddr), .o_s_arlen(s_arlen), .o_s_arsize(s_arsize),
    .o_s_arburst(s_arburst), .o_s_arvalid(s_arvalid), .i_s_arready(s_arready),
    .i_s_rid(s_rid), .i_s_rdata(s_rdata), .i_s_rresp(s_rresp), .i_s_rlast(s_rlast),
    .i_s_rvalid(s_rvalid), .o_s_rready(s_rready),
    .o_dbg_wstate(dbg_wstate), .o_dbg_rstate(dbg_rstate)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] wbeat(input int b);
    return 64'hCAFE_0000_0000_0000 + 64'(b);
  endfunction

  function automatic logic [63:0] rbeat(input int b);
    return 64'hBEEF_0000_0000_0000 + 64'(b);
  endfunction

  task automatic init_inputs();
    for (int m = 0; m < 2; m++) begin
      m_awid[m] = '0; m_awaddr[m] = '0; m_awlen[m] = '0; m_awsize[m] = 3'd3; m_awburst[m] = 2'd1;
      m_wdata[m] = '0; m_wstrb[m] = '1;
      m_arid[m] = '0; m_araddr[m] = '0; m_arlen[m] = '0; m_arsize[m] = 3'd3; m_arburst[m] = 2'd1;
    end
    m_awvalid = '0; m_wlast = '0; m_wvalid = '0; m_bready = '0; m_arvalid = '0; m_rready = '0;
    s_awready = 0; s_wready = 0; s_bid = '0; s_bresp = '0; s_bvalid = 0;
    s_arready = 0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 0; s_rvalid = 0;
  endtask

  initial begin
    // clock/reset
    init_inputs();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_awvalid", s_awvalid, 0);
    chk("rst_s_arvalid", s_arvalid, 0);
    chk("rst_wstate", dbg_wstate, 0);
    chk("rst_rstate", dbg_rstate, 0);
    chk("rst_m_rvalid", m_rvalid, 0);
    rstn = 1'b1;
    tick();

    // m0 write, len=3, wvalid raised early, 5-cycle slave stall on beat 2
    m_awvalid[0] = 1; m_awid[0] = 4'd3; m_awaddr[0] = 32'h100; m_awlen[0] = 8'd3;
    m_wvalid[0] = 1; m_wdata[0] = wbeat(0); m_wlast[0] = 0;
    #1;
    chk("t1_idle_s_awvalid", s_awvalid, 0);
    chk("t1_idle_m0_awready", m_awready[0], 0);
    tick();
    chk("t1_s_awvalid", s_awvalid, 1);
    chk("t1_s_awaddr", s_awaddr, 32'h100);
    chk("t1_s_awid", s_awid, 3);
    chk("t1_s_awlen", s_awlen, 3);
    chk("t1_early_wready", m_wready[0], 0);
    chk("t1_early_s_wvalid", s_wvalid, 0);
    s_awready = 1;
    #1;
    chk("t1_m0_awready", m_awready[0], 1);
    chk("t1_m1_awready", m_awready[1], 0);
    tick();
    m_awvalid[0] = 0; s_awready = 0; s_wready = 1;
    for (int b = 0; b < 4; b++) begin
      m_wdata[0] = wbeat(b); m_wlast[0] = (b == 3);
      if (b == 2) begin
        s_wready = 0;
        for (int k = 0; k < 5; k++) begin
          #1;
          chk("t5_stall_m0_wready", m_wready[0], 0);
          chk("t5_stall_s_wdata", s_wdata, wbeat(2));
          tick();
        end
        s_wready = 1;
      end
      #1;
      chk("t1_s_wvalid", s_wvalid, 1);
      chk("t1_s_wdata", s_wdata, wbeat(b));
      chk("t1_s_wlast", s_wlast, (b == 3));
      chk("t1_m0_wready", m_wready[0], 1);
      tick();
    end
    m_wvalid[0] = 0; m_wlast[0] = 0; s_wready = 0;
    s_bvalid = 1; s_bid = 4'd3; s_bresp = 2'd0; m_bready[0] = 1;
    #1;
    chk("t1_wstate_resp", dbg_wstate, 3);
    chk("t1_m0_bvalid", m_bvalid[0], 1);
    chk("t1_m0_bid", m_bid[0], 3);
    chk("t1_m0_bresp", m_bresp[0], 0);
    chk("t1_m1_bvalid", m_bvalid[1], 0);
    chk("t1_s_bready", s_bready, 1);
    tick();
    s_bvalid = 0; m_bready[0] = 0;
    #1;
    chk("t1_wstate_idle", dbg_wstate, 0);
    chk("t1_m0_bvalid_off", m_bvalid[0], 0);

    // contended single-beat reads: grants alternate m0,m1,m0,m1; m1 gets SLVERR, rid=5
    m_arid[0] = 4'd1; m_arid[1] = 4'd5; m_araddr[0] = 32'h2000; m_araddr[1] = 32'h3000;
    for (int i = 0; i < 4; i++) begin
      int g;
      g = i % 2;
      m_arvalid = 2'b11;
      #1;
      chk("t2_idle_s_arvalid", s_arvalid, 0);
      tick();
      chk("t2_grant_arid", s_arid, (g == 1) ? 5 : 1);
      chk("t2_grant_araddr", s_araddr, (g == 1) ? 32'h3000 : 32'h2000);
      s_arready = 1;
      #1;
      chk("t2_arready_gnt", m_arready[g], 1);
      chk("t2_arready_other", m_arready[1-g], 0);
      tick();
      m_arvalid[g] = 0; s_arready = 0;
      s_rvalid = 1; s_rid = (g == 1) ? 4'd5 : 4'd1; s_rdata = rbeat(i);
      s_rresp = (g == 1) ? 2'd2 : 2'd0; s_rlast = 1; m_rready[g] = 1;
      #1;
      chk("t2_rvalid_gnt", m_rvalid[g], 1);
      chk("t4_rvalid_other", m_rvalid[1-g], 0);
      chk("t4_rid", m_rid[g], (g == 1) ? 5 : 1);
      chk("t4_rresp", m_rresp[g], (g == 1) ? 2 : 0);
      chk("t2_rdata", m_rdata[g], rbeat(i));
      chk("t2_rdata_other", m_rdata[1-g], 0);
      chk("t2_s_rready", s_rready, 1);
      tick();
      s_rvalid = 0; s_rlast = 0; m_rready[g] = 0;
    end
    m_arvalid = 2'b00;

    // m0 write (len=3) concurrent with m1 read (len=7)
    m_awvalid[0] = 1; m_awid[0] = 4'd2; m_awaddr[0] = 32'h400; m_awlen[0] = 8'd3;
    m_arvalid[1] = 1; m_arid[1] = 4'd6; m_araddr[1] = 32'h800; m_arlen[1] = 8'd7;
    tick();
    chk("t3_s_awvalid", s_awvalid, 1);
    chk("t3_s_awaddr", s_awaddr, 32'h400);
    chk("t3_s_arvalid", s_arvalid, 1);
    chk("t3_s_araddr", s_araddr, 32'h800);
    chk("t3_s_arlen", s_arlen, 7);
    s_awready = 1; s_arready = 1;
    #1;
    chk("t3_m0_awready", m_awready[0], 1);
    chk("t3_m1_arready", m_arready[1], 1);
    chk("t3_m0_arready", m_arready[0], 0);
    tick();
    m_awvalid[0] = 0; m_arvalid[1] = 0; s_awready = 0; s_arready = 0;
    m_wvalid[0] = 1; s_wready = 1; m_rready[1] = 1; s_rvalid = 1; s_rid = 4'd6; s_rresp = 2'd0;
    s_bid = 4'd2; s_bresp = 2'd0; m_bready[0] = 1;
    for (int c = 0; c < 8; c++) begin
      s_rdata = rbeat(c); s_rlast = (c == 7);
      if (c < 4) begin
        m_wdata[0] = wbeat(10 + c); m_wlast[0] = (c == 3);
      end else begin
        m_wvalid[0] = 0; m_wlast[0] = 0; s_bvalid = (c == 4);
      end
      #1;
      chk("t3_m1_rvalid", m_rvalid[1], 1);
      chk("t3_m1_rdata", m_rdata[1], rbeat(c));
      chk("t3_m1_rlast", m_rlast[1], (c == 7));
      chk("t3_m0_rvalid", m_rvalid[0], 0);
      if (c < 4) begin
        chk("t3_s_wvalid", s_wvalid, 1);
        chk("t3_s_wdata", s_wdata, wbeat(10 + c));
        chk("t3_m0_wready", m_wready[0], 1);
      end
      if (c == 4) begin
        chk("t3_m0_bvalid", m_bvalid[0], 1);
        chk("t3_m0_bid", m_bid[0], 2);
      end
      if (c == 5) chk("t3_wstate_idle", dbg_wstate, 0);
      tick();
    end
    s_rvalid = 0; s_rlast = 0; m_rready[1] = 0; s_bvalid = 0; m_bready[0] = 0;
    #1;
    chk("t3_rstate_idle", dbg_rstate, 0);
    chk("t3_wstate_idle2", dbg_wstate, 0);

    // reset while in W_DATA, then write contention must go to m0
    m_awvalid[0] = 1; m_awid[0] = 4'd7; m_awaddr[0] = 32'h500; m_awlen[0] = 8'd1;
    tick();
    s_awready = 1;
    tick();
    m_awvalid[0] = 0; s_awready = 0;
    m_wvalid[0] = 1; m_wdata[0] = wbeat(20); m_wlast[0] = 0; s_wready = 1;
    #1;
    chk("t6_pre_s_wvalid", s_wvalid, 1);
    chk("t6_pre_wstate", dbg_wstate, 2);
    rstn = 1'b0;
    #1;
    chk("t6_rst_s_wvalid", s_wvalid, 0);
    chk("t6_rst_m0_wready", m_wready[0], 0);
    chk("t6_rst_wstate", dbg_wstate, 0);
    init_inputs();
    tick();
    rstn = 1'b1;
    m_awvalid = 2'b11; m_awid[0] = 4'd8; m_awid[1] = 4'd9;
    m_awaddr[0] = 32'h600; m_awaddr[1] = 32'h700;
    tick();
    chk("t6_grant_awid", s_awid, 8);
    chk("t6_grant_awaddr", s_awaddr, 32'h600);
    chk("t6_wstate_addr", dbg_wstate, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
